depuncturer_wifi: RTL and testbench

Receive-side depuncturer for the WIFI PHY. It sits directly downstream of the 192-bit deinterleaver and upstream of the Viterbi decoder. It takes the deinterleaver's serial bit stream and its finished level, and restores the rate-1/2 mother-code pairs (A,B) with per-bit erasure flags for rates 1/2, 2/3 and 3/4. It emits at most one pair per clock, so no backpressure is needed.

---
 rtl/wifi_rx_pkg.sv | 52 +++++
 rtl/depuncture_pattern_lut.sv | 42 ++++
 rtl/depuncturer_wifi.sv | 177 +++++++++++++++++
 tb/tb_depuncturer_wifi.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wifi_rx_pkg.sv
// Shared WIFI receive-path definitions: rate codes, depuncturer FSM states,
// puncturing pattern lengths and the output pair payload.
package wifi_rx_pkg;

  localparam int unsigned NCBPS    = 192;
  localparam int unsigned RATE_W   = 2;
  localparam int unsigned PHASE_W  = 2;

  // Number of punctured input bits per pattern period.
  localparam int unsigned PLEN_1_2 = 2;
  localparam int unsigned PLEN_2_3 = 3;
  localparam int unsigned PLEN_3_4 = 4;

  typedef enum logic [RATE_W-1:0] {
    RATE_1_2 = 2'b00,
    RATE_2_3 = 2'b01,
    RATE_3_4 = 2'b10
  } rate_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Restored mother-code pair with per-bit erasure flags.
  typedef struct packed {
    logic a;
    logic b;
    logic erase_a;
    logic erase_b;
  } pair_t;

  // Reserved code 11 decodes as rate 1/2.
  function automatic rate_e decode_rate(input logic [RATE_W-1:0] code);
    case (code)
      2'b01:   return RATE_2_3;
      2'b10:   return RATE_3_4;
      default: return RATE_1_2;
    endcase
  endfunction

  // Phase index of the final bit in a pattern period.
  function automatic logic [PHASE_W-1:0] pattern_last_phase(input rate_e r);
    case (r)
      RATE_2_3: return PHASE_W'(PLEN_2_3 - 1);
      RATE_3_4: return PHASE_W'(PLEN_3_4 - 1);
      default:  return PHASE_W'(PLEN_1_2 - 1);
    endcase
  endfunction

endpackage

// File: rtl/depuncture_pattern_lut.sv
// Combinational puncturing pattern table.
// Ports:
//   rate           latched code rate
//   phase          position of the current bit within the pattern period
//   emit_c         current bit completes a mother-code pair
//   erase_a_c      A of that pair is an inserted erasure
//   erase_b_c      B of that pair is an inserted erasure
//   pattern_last_c current bit is the last of the period (phase wraps)
module depuncture_pattern_lut
  import wifi_rx_pkg::*;
(
  input  rate_e              rate,
  input  logic [PHASE_W-1:0] phase,
  output logic               emit_c,
  output logic               erase_a_c,
  output logic               erase_b_c,
  output logic               pattern_last_c
);

  // Phase 0 always only holds A; later phases emit per rate.
  always_comb begin
    emit_c         = 1'b0;
    erase_a_c      = 1'b0;
    erase_b_c      = 1'b0;
    pattern_last_c = (phase == pattern_last_phase(rate));
    case (rate)
      RATE_2_3: begin
        emit_c    = (phase != PHASE_W'(0));
        erase_b_c = (phase == PHASE_W'(2));
      end
      RATE_3_4: begin
        emit_c    = (phase != PHASE_W'(0));
        erase_b_c = (phase == PHASE_W'(2));
        erase_a_c = (phase == PHASE_W'(3));
      end
      default: begin
        emit_c = (phase == PHASE_W'(1));
      end
    endcase
  end

endmodule

// File: rtl/depuncturer_wifi.sv
// Receive-side depuncturer: turns the deinterleaver's serial hard bits back
// into rate-1/2 mother-code pairs (A,B) with erasure flags for the Viterbi.
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   enable            0 stalls bit acceptance (edge detect and flush still run)
//   rate              code rate, latched on the first bit of a frame
//   data_in/valid_in  serial bit stream from the deinterleaver
//   finished_in       deinterleaver finished level; rising edge closes a frame
//   data_a/data_b     restored pair (0 where erased)
//   erase_a/erase_b   erasure flags
//   valid_out         one-cycle pair qualifier
//   frame_done        one-cycle end-of-frame pulse
//   pair_count        saturating count of pairs in the current/last frame
//   odd_error         frame ended mid-pattern; sticky until next frame start
module depuncturer_wifi
  import wifi_rx_pkg::*;
#(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [RATE_W-1:0]  rate,
  input  logic               data_in,
  input  logic               valid_in,
  input  logic               finished_in,
  output logic               data_a,
  output logic               data_b,
  output logic               erase_a,
  output logic               erase_b,
  output logic               valid_out,
  output logic               frame_done,
  output logic [COUNT_W-1:0] pair_count,
  output logic               odd_error
);

  state_e               state_q, state_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  rate_e                rate_q, rate_d;
  logic                 held_q, held_d;
  logic                 fin_prev_q;
  pair_t                pair_q, pair_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 odd_q, odd_d;

  logic                 accept;
  logic                 fin_rise;
  logic                 take_bit;
  rate_e                lut_rate;
  logic                 lut_emit;
  logic                 lut_erase_a;
  logic                 lut_erase_b;
  logic                 lut_last;

  assign accept   = enable & valid_in;
  assign fin_rise = finished_in & ~fin_prev_q;

  // The first bit of a frame is decoded with the rate presented alongside it.
  assign lut_rate = (state_q == IDLE) ? decode_rate(rate) : rate_q;

  depuncture_pattern_lut u_lut (
    .rate           (lut_rate),
    .phase          (phase_q),
    .emit_c         (lut_emit),
    .erase_a_c      (lut_erase_a),
    .erase_b_c      (lut_erase_b),
    .pattern_last_c (lut_last)
  );

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    rate_d   = rate_q;
    held_d   = held_q;
    pair_d   = '0;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    count_d  = count_q;
    odd_d    = odd_q;
    take_bit = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = RUN;
          rate_d   = lut_rate;
          count_d  = '0;
          odd_d    = 1'b0;
          take_bit = 1'b1;
        end
      end
      RUN: begin
        // A bit arriving with the finished edge still belongs to this frame.
        take_bit = accept;
        if (fin_rise) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        state_d = IDLE;
        phase_d = '0;
        done_d  = 1'b1;
        if (phase_q == PHASE_W'(1)) begin
          // Orphaned A: release it with B erased.
          valid_d        = 1'b1;
          pair_d.a       = held_q;
          pair_d.erase_b = 1'b1;
          odd_d          = 1'b1;
        end else if (rate_q == RATE_3_4 && phase_q == PHASE_W'(PLEN_3_4 - 1)) begin
          odd_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (take_bit) begin
      phase_d = lut_last ? '0 : phase_q + PHASE_W'(1);
      if (lut_emit) begin
        valid_d        = 1'b1;
        pair_d.erase_a = lut_erase_a;
        pair_d.erase_b = lut_erase_b;
        // Only phase 1 pairs the current bit with a held A.
        pair_d.a       = lut_erase_a ? 1'b0 :
                         ((phase_q == PHASE_W'(1)) ? held_q : data_in);
        pair_d.b       = lut_erase_b ? 1'b0 : data_in;
      end else begin
        held_d = data_in;
      end
    end

    if (valid_d && (count_d != '1)) begin
      count_d = count_d + COUNT_W'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      rate_q     <= RATE_1_2;
      held_q     <= 1'b0;
      fin_prev_q <= 1'b1;   // stuck-high finished_in must not look like an edge
      pair_q     <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= '0;
      odd_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      rate_q     <= rate_d;
      held_q     <= held_d;
      fin_prev_q <= finished_in;
      pair_q     <= pair_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      count_q    <= count_d;
      odd_q      <= odd_d;
    end
  end

  assign data_a     = pair_q.a;
  assign data_b     = pair_q.b;
  assign erase_a    = pair_q.erase_a;
  assign erase_b    = pair_q.erase_b;
  assign valid_out  = valid_q;
  assign frame_done = done_q;
  assign pair_count = count_q;
  assign odd_error  = odd_q;

endmodule

// File: tb/tb_depuncturer_wifi.sv
`timescale 1ns/1ps
module tb_depuncturer_wifi;

  localparam int unsigned CW   = 8;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [1:0]    rate;
  logic          data_in;
  logic          valid_in;
  logic          finished_in;
  logic          data_a;
  logic          data_b;
  logic          erase_a;
  logic          erase_b;
  logic          valid_out;
  logic          frame_done;
  logic [CW-1:0] pair_count;
  logic          odd_error;

  always #5 clk = ~clk;

  depuncturer_wifi #(.COUNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .rate        (rate),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .finished_in (finished_in),
    .data_a      (data_a),
    .data_b      (data_b),
    .erase_a     (erase_a),
    .erase_b     (erase_b),
    .valid_out   (valid_out),
    .frame_done  (frame_done),
    .pair_count  (pair_count),
    .odd_error   (odd_error)
  );

  typedef struct {
    logic [1:0] rate;
    int         n;
    int         pat;        // 0 random, 1 alternating 1,0, 2 fixed 1101101
    int         stall_at;   // bit index before which enable drops
    int         stall_len;
    bit         sim_fin;    // finished rises with the last bit
    bit         rate_chg;   // rate input changes after the first bit
    bit         flush_valid;// valid_in pulsed during the flush cycle
    bit         en_low_fin; // enable low while the frame closes
    bit         use_model;  // expectations taken from the reference model
    int         exp_pairs;
    int         exp_count;
    bit         exp_odd;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] got_q[$];
  int         done_total = 0;
  logic [CW-1:0] done_count = '0;
  logic       done_odd = 1'b0;
  logic       done_pair = 1'b0;
  logic       fbits[$];
  vec_t       tbl[12];

  // Output monitor: records every pair and the frame_done snapshot.
  always @(negedge clk) begin
    if (valid_out === 1'b1) got_q.push_back({data_a, data_b, erase_a, erase_b});
    if (frame_done === 1'b1) begin
      done_total = done_total + 1;
      done_count = pair_count;
      done_odd   = odd_error;
      done_pair  = valid_out;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: each full group of L input bits maps onto the puncture matrix
  // of its rate; a trailing partial group yields what was already complete
  // plus a B-erased pair if an A is left alone.
  task automatic model(input logic [1:0] r, input logic bits[$],
                       output logic [3:0] exp[$], output bit odd, output bit fpair);
    int len, full, rem, bse;
    exp.delete();
    odd   = 1'b0;
    fpair = 1'b0;
    len   = (r == 2'b01) ? 3 : (r == 2'b10) ? 4 : 2;
    full  = bits.size() / len;
    rem   = bits.size() % len;
    for (int g = 0; g < full; g++) begin
      bse = g * len;
      exp.push_back({bits[bse], bits[bse+1], 2'b00});
      if (len >= 3) exp.push_back({bits[bse+2], 1'b0, 2'b01});
      if (len == 4) exp.push_back({1'b0, bits[bse+3], 2'b10});
    end
    bse = full * len;
    if (rem == 1) begin
      exp.push_back({bits[bse], 1'b0, 2'b01});
      odd   = 1'b1;
      fpair = 1'b1;
    end
    if (rem >= 2) exp.push_back({bits[bse], bits[bse+1], 2'b00});
    if (rem == 3) begin
      exp.push_back({bits[bse+2], 1'b0, 2'b01});
      odd = 1'b1;
    end
  endtask

  function automatic vec_t mk(input logic [1:0] r, input int n, input int pat,
                              input int sa, input int sl, input bit sf, input bit rc,
                              input bit fv, input bit el, input int ep, input int ec,
                              input bit eo);
    vec_t v;
    v.rate = r; v.n = n; v.pat = pat; v.stall_at = sa; v.stall_len = sl;
    v.sim_fin = sf; v.rate_chg = rc; v.flush_valid = fv; v.en_low_fin = el;
    v.use_model = 1'b0; v.exp_pairs = ep; v.exp_count = ec; v.exp_odd = eo;
    return v;
  endfunction

  task automatic wait_done(input int db, input string name);
    int t;
    t = 0;
    while (done_total == db && t < 20) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    if (done_total == db) begin
      errors++;
      checks++;
      $display("FAIL %s timeout: got no frame_done expected one within 20 cycles", name);
    end
  endtask

  task automatic run_vec(input vec_t vin, input string name);
    vec_t       v;
    logic [3:0] exp[$];
    logic [6:0] p7;
    bit         m_odd, m_fpair;
    int         gb, db, mism, ngot;
    v  = vin;
    p7 = 7'b1101101;
    fbits.delete();
    for (int i = 0; i < v.n; i++) begin
      case (v.pat)
        1:       fbits.push_back(~i[0]);
        2:       fbits.push_back(p7[6-i]);
        default: fbits.push_back(1'($urandom));
      endcase
    end
    model(v.rate, fbits, exp, m_odd, m_fpair);
    if (v.use_model) begin
      v.exp_pairs = exp.size();
      v.exp_count = (exp.size() > CMAX) ? CMAX : exp.size();
      v.exp_odd   = m_odd;
    end
    gb = got_q.size();
    db = done_total;

    for (int i = 0; i < v.n; i++) begin
      if (i == v.stall_at) begin
        for (int s = 0; s < v.stall_len; s++) begin
          @(negedge clk);
          enable = 1'b0; valid_in = 1'b1; data_in = 1'($urandom);
        end
      end
      @(negedge clk);
      enable = 1'b1; valid_in = 1'b1; data_in = fbits[i]; finished_in = 1'b0;
      rate = (i == 0 || !v.rate_chg) ? v.rate : ~v.rate;
      if (v.sim_fin && i == v.n - 1) finished_in = 1'b1;
    end
    if (!v.sim_fin) begin
      @(negedge clk);
      valid_in = 1'b0; finished_in = 1'b1; enable = ~v.en_low_fin;
    end
    @(negedge clk);
    enable = 1'b1; valid_in = v.flush_valid; data_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    wait_done(db, name);

    ngot = got_q.size() - gb;
    check({name, " pairs"}, 32'(ngot), 32'(v.exp_pairs));
    check({name, " model_len"}, 32'(ngot), 32'(exp.size()));
    mism = 0;
    for (int j = 0; j < ngot && j < exp.size(); j++)
      if (got_q[gb+j] !== exp[j]) mism++;
    check({name, " content_mismatches"}, 32'(mism), 32'd0);
    check({name, " done_pulses"}, 32'(done_total - db), 32'd1);
    check({name, " count_at_done"}, 32'(done_count), 32'(v.exp_count));
    check({name, " odd_at_done"}, 32'(done_odd), 32'(v.exp_odd));
    check({name, " flush_pair"}, 32'(done_pair), 32'(m_fpair));
    check({name, " odd_sticky"}, 32'(odd_error), 32'(v.exp_odd));
    check({name, " count_hold"}, 32'(pair_count), 32'(v.exp_count));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test expected finish before 1ms");
    $fatal(1);
  end

  initial begin
    int   db;
    vec_t rv;

    //    rate   n  pat sa  sl sf rc fv el  pairs count odd
    tbl[0]  = mk(2'b00, 192, 1,  -1, 0, 0, 0, 0, 0,  96,  96, 0);
    tbl[1]  = mk(2'b10, 192, 0,  -1, 0, 0, 0, 0, 0, 144, 144, 0);
    tbl[2]  = mk(2'b01, 192, 0,  -1, 0, 0, 0, 0, 0, 128, 128, 0);
    tbl[3]  = mk(2'b00,   7, 2,  -1, 0, 0, 0, 0, 0,   4,   4, 1);
    tbl[4]  = mk(2'b10,   8, 0,   5, 3, 0, 0, 0, 0,   6,   6, 0);
    tbl[5]  = mk(2'b11,   6, 0,  -1, 0, 0, 0, 0, 0,   3,   3, 0);
    tbl[6]  = mk(2'b01,   8, 0,  -1, 0, 1, 0, 0, 0,   5,   5, 0);
    tbl[7]  = mk(2'b10,   5, 0,  -1, 0, 0, 0, 1, 0,   4,   4, 1);
    tbl[8]  = mk(2'b10,   7, 0,  -1, 0, 0, 1, 0, 0,   5,   5, 1);
    tbl[9]  = mk(2'b01,   4, 0,  -1, 0, 0, 0, 0, 1,   3,   3, 1);
    tbl[10] = mk(2'b00, 600, 0,  -1, 0, 0, 0, 0, 0, 300, 255, 0);
    tbl[11] = mk(2'b01,   3, 0,   0, 2, 0, 0, 0, 0,   2,   2, 0);

    reset = 1'b0; enable = 1'b0; rate = 2'b00; data_in = 1'b0;
    valid_in = 1'b0; finished_in = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({data_a, data_b, erase_a, erase_b, valid_out, frame_done, odd_error}), 32'd0);
    check("reset_count", 32'(pair_count), 32'd0);
    reset = 1'b1; enable = 1'b1;

    // finished_in held high out of reset must not close a frame.
    repeat (6) @(negedge clk);
    check("stuck_high_finished", 32'(done_total), 32'd0);

    // First pair appears the cycle after its completing bit.
    db = done_total;
    valid_in = 1'b1; data_in = 1'b1; finished_in = 1'b0; rate = 2'b00;
    @(negedge clk);
    data_in = 1'b0;
    check("latency_before", 32'(valid_out), 32'd0);
    @(negedge clk);
    valid_in = 1'b0;
    check("latency_valid", 32'(valid_out), 32'd1);
    check("latency_pair", 32'({data_a, data_b, erase_a, erase_b}), 32'b1000);
    @(negedge clk);
    check("latency_single", 32'(valid_out), 32'd0);
    finished_in = 1'b1;
    wait_done(db, "latency_frame");
    check("latency_count", 32'(pair_count), 32'd1);

    for (int k = 0; k < 12; k++) run_vec(tbl[k], $sformatf("vec%0d", k));

    // Reset in the middle of a frame discards it silently.
    db = done_total;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      enable = 1'b1; valid_in = 1'b1; data_in = 1'($urandom);
      finished_in = 1'b0; rate = 2'b00;
    end
    @(negedge clk);
    valid_in = 1'b0; reset = 1'b0; finished_in = 1'b1;
    @(negedge clk);
    check("midreset_outputs", 32'({data_a, data_b, erase_a, erase_b, valid_out, frame_done, odd_error}), 32'd0);
    check("midreset_count", 32'(pair_count), 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("midreset_no_done", 32'(done_total - db), 32'd0);
    run_vec(tbl[0], "post_reset");

    // Randomized frames against the reference model.
    for (int k = 0; k < 10; k++) begin
      rv = mk(2'(($urandom_range(0, 3))), $urandom_range(2, 50), 0, -1, 0,
              1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0, 0, 0);
      if (rv.rate == 2'b10 && (rv.n % 4) == 2) rv.n = rv.n + 1;
      rv.stall_at  = $urandom_range(0, rv.n - 1);
      rv.stall_len = $urandom_range(0, 3);
      rv.use_model = 1'b1;
      run_vec(rv, $sformatf("rand%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
